// File: rtl/instruction_sequencer_if.sv
// Control bus between the instruction sequencer and the surrounding datapath
// (instruction register, ALU, register file, program counter).
interface instruction_sequencer_if #(
    parameter int unsigned PC_WIDTH = 13
);
    logic [13:0]         instr_current;
    logic [PC_WIDTH-1:0] pc_next_addr;
    logic                bit_test_res;
    logic                status_z;

    logic [1:0]          q_phase;
    logic [3:0]          alu_op;
    logic                alu_sel_l;
    logic                alu_status_wr_en;
    logic                f_wr_en;
    logic                w_wr_en;
    logic                instr_rd_en;
    logic                instr_flush;
    logic                pc_incr_en;
    logic                pc_j_en;
    logic                pc_ret_en;
    logic [PC_WIDTH-1:0] ret_addr;
    logic                stack_overflow;
    logic                stack_underflow;
    logic                illegal_instr;

    // Datapath side: supplies the instruction and status, consumes controls.
    modport master (
        output instr_current, pc_next_addr, bit_test_res, status_z,
        input  q_phase, alu_op, alu_sel_l, alu_status_wr_en, f_wr_en, w_wr_en,
               instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_ret_en, ret_addr,
               stack_overflow, stack_underflow, illegal_instr
    );

    // Sequencer side.
    modport slave (
        input  instr_current, pc_next_addr, bit_test_res, status_z,
        output q_phase, alu_op, alu_sel_l, alu_status_wr_en, f_wr_en, w_wr_en,
               instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_ret_en, ret_addr,
               stack_overflow, stack_underflow, illegal_instr
    );
endinterface

// File: rtl/instruction_sequencer.sv
// PIC14 instruction sequencer: 4-Q-cycle control decode, hardware return
// stack (circular, overwrite-on-full) and sticky fault flags.
// ALU op codes: 0 add, 1 sub, 2 and, 3 ior, 4 xor, 5 com, 6 dec, 7 inc,
// 8 rlf, 9 rrf, 10 swap, 11 clr, 12 passw, 13 passlf, 14 bc, 15 bs.
module instruction_sequencer #(
    parameter int unsigned PC_WIDTH    = 13,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_sequencer_if.slave bus
);
    localparam int unsigned SpW  = $clog2(STACK_DEPTH);
    localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
    localparam logic [SpW-1:0]  SpOne   = SpW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(STACK_DEPTH);

    localparam logic [3:0] AluAdd = 4'd0,  AluSub = 4'd1,  AluAnd = 4'd2,  AluIor = 4'd3;
    localparam logic [3:0] AluXor = 4'd4,  AluCom = 4'd5,  AluDec = 4'd6,  AluInc = 4'd7;
    localparam logic [3:0] AluRlf = 4'd8,  AluRrf = 4'd9,  AluSwap = 4'd10, AluClr = 4'd11;
    localparam logic [3:0] AluPassW = 4'd12, AluPassLf = 4'd13, AluBc = 4'd14, AluBs = 4'd15;

    typedef enum logic [1:0] {StQ0, StQ1, StQ2, StQ3} q_state_e;
    typedef enum logic [2:0] {KindSeq, KindSkip, KindJump, KindCall, KindRet} kind_e;

    q_state_e q_q, q_d;

    logic [13:0] ir;
    logic [3:0]  dec_op;
    logic        dec_sel_l, dec_st, dec_fw, dec_ww, dec_byte, dec_skip_z, dec_legal;
    kind_e       dec_kind;
    logic        skip, push, pop;

    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SpW-1:0]      sp_q;
    logic [CntW-1:0]     cnt_q;
    logic                ovf_q, unf_q, ill_q;

    assign ir = bus.instr_current;

    // Q-phase state register.
    always_ff @(posedge clk) begin
        if (rst) q_q <= StQ0;
        else     q_q <= q_d;
    end

    // Q-phase next state: free-running 0..3.
    always_comb begin
        q_d = StQ0;
        unique case (q_q)
            StQ0: q_d = StQ1;
            StQ1: q_d = StQ2;
            StQ2: q_d = StQ3;
            default: q_d = StQ0;
        endcase
    end

    // Instruction decode into ALU/writeback fields and an end-of-slot kind.
    always_comb begin
        dec_op     = AluAdd;
        dec_sel_l  = 1'b0;
        dec_st     = 1'b0;
        dec_fw     = 1'b0;
        dec_ww     = 1'b0;
        dec_byte   = 1'b0;
        dec_skip_z = 1'b0;
        dec_legal  = 1'b1;
        dec_kind   = KindSeq;
        casez (ir)
            14'b00_0000_1???_????: begin dec_op = AluPassW; dec_fw = 1'b1; end
            14'b00_0000_0??0_0000: ;
            14'b00_0000_0000_1000: dec_kind = KindRet;
            14'b00_0001_????_????: begin dec_op = AluClr;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_0010_????_????: begin dec_op = AluSub;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_0011_????_????: begin dec_op = AluDec;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_0100_????_????: begin dec_op = AluIor;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_0101_????_????: begin dec_op = AluAnd;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_0110_????_????: begin dec_op = AluXor;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_0111_????_????: begin dec_op = AluAdd;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_1000_????_????: begin dec_op = AluPassLf; dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_1001_????_????: begin dec_op = AluCom;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_1010_????_????: begin dec_op = AluInc;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_1011_????_????: begin
                dec_op = AluDec; dec_byte = 1'b1; dec_st = 1'b1;
                dec_kind = KindSkip; dec_skip_z = 1'b1;
            end
            14'b00_1100_????_????: begin dec_op = AluRrf;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_1101_????_????: begin dec_op = AluRlf;  dec_byte = 1'b1; dec_st = 1'b1; end
            14'b00_1110_????_????: begin dec_op = AluSwap; dec_byte = 1'b1; end
            14'b00_1111_????_????: begin
                dec_op = AluInc; dec_byte = 1'b1; dec_st = 1'b1;
                dec_kind = KindSkip; dec_skip_z = 1'b1;
            end
            14'b01_00??_????_????: begin dec_op = AluBc; dec_fw = 1'b1; end
            14'b01_01??_????_????: begin dec_op = AluBs; dec_fw = 1'b1; end
            14'b01_10??_????_????: begin dec_op = AluBc; dec_kind = KindSkip; end
            14'b01_11??_????_????: begin dec_op = AluBs; dec_kind = KindSkip; end
            14'b10_0???_????_????: dec_kind = KindCall;
            14'b10_1???_????_????: dec_kind = KindJump;
            14'b11_00??_????_????: begin dec_op = AluPassLf; dec_sel_l = 1'b1; dec_ww = 1'b1; end
            14'b11_01??_????_????: begin
                dec_op = AluPassLf; dec_sel_l = 1'b1; dec_ww = 1'b1; dec_kind = KindRet;
            end
            14'b11_1000_????_????: begin
                dec_op = AluIor; dec_sel_l = 1'b1; dec_ww = 1'b1; dec_st = 1'b1;
            end
            14'b11_1001_????_????: begin
                dec_op = AluAnd; dec_sel_l = 1'b1; dec_ww = 1'b1; dec_st = 1'b1;
            end
            14'b11_1010_????_????: begin
                dec_op = AluXor; dec_sel_l = 1'b1; dec_ww = 1'b1; dec_st = 1'b1;
            end
            14'b11_110?_????_????: begin
                dec_op = AluSub; dec_sel_l = 1'b1; dec_ww = 1'b1; dec_st = 1'b1;
            end
            14'b11_111?_????_????: begin
                dec_op = AluAdd; dec_sel_l = 1'b1; dec_ww = 1'b1; dec_st = 1'b1;
            end
            default: dec_legal = 1'b0;  // runs as NOP
        endcase
        // Byte-oriented ops route the result by the d bit.
        if (dec_byte) begin
            dec_fw = ir[7];
            dec_ww = ~ir[7];
        end
    end

    assign skip = dec_skip_z ? bus.status_z : bus.bit_test_res;
    assign push = (q_q == StQ3) && (dec_kind == KindCall);
    assign pop  = (q_q == StQ3) && (dec_kind == KindRet);

    // Phase-gated control outputs; everything is 0 unless a decode asserts it.
    always_comb begin
        bus.alu_op           = 4'd0;
        bus.alu_sel_l        = 1'b0;
        bus.alu_status_wr_en = 1'b0;
        bus.f_wr_en          = 1'b0;
        bus.w_wr_en          = 1'b0;
        bus.instr_rd_en      = 1'b0;
        bus.instr_flush      = 1'b0;
        bus.pc_incr_en       = 1'b0;
        bus.pc_j_en          = 1'b0;
        bus.pc_ret_en        = 1'b0;
        if (q_q == StQ2) begin
            bus.alu_op           = dec_op;
            bus.alu_sel_l        = dec_sel_l;
            bus.alu_status_wr_en = dec_st;
            bus.f_wr_en          = dec_fw;
            bus.w_wr_en          = dec_ww;
        end else if (q_q == StQ3) begin
            unique case (dec_kind)
                KindSkip: begin
                    bus.pc_incr_en  = 1'b1;
                    bus.instr_flush = skip;
                    bus.instr_rd_en = ~skip;
                end
                KindJump, KindCall: begin
                    bus.pc_j_en     = 1'b1;
                    bus.instr_flush = 1'b1;
                end
                KindRet: begin
                    bus.pc_ret_en   = 1'b1;
                    bus.instr_flush = 1'b1;
                end
                default: begin
                    bus.instr_rd_en = 1'b1;
                    bus.pc_incr_en  = 1'b1;
                end
            endcase
        end
    end

    // Return stack, depth count and sticky fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            if (push) begin
                stack_q[sp_q] <= bus.pc_next_addr;
                sp_q          <= sp_q + SpOne;
                if (cnt_q == CntFull) ovf_q <= 1'b1;
                else                  cnt_q <= cnt_q + CntOne;
            end else if (pop) begin
                sp_q <= sp_q - SpOne;
                if (cnt_q == '0) unf_q <= 1'b1;
                else             cnt_q <= cnt_q - CntOne;
            end
            if ((q_q == StQ3) && !dec_legal) ill_q <= 1'b1;
        end
    end

    assign bus.q_phase         = q_q;
    assign bus.ret_addr        = stack_q[sp_q - SpOne];
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
    assign bus.illegal_instr   = ill_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with hand-computed expectations.
module tb_instruction_sequencer;
    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluXor = 4'd4, AluDec = 4'd6;
    localparam logic [3:0] AluSwap = 4'd10, AluClr = 4'd11, AluPassW = 4'd12;
    localparam logic [3:0] AluPassLf = 4'd13, AluBc = 4'd14, AluBs = 4'd15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    instruction_sequencer_if #(.PC_WIDTH(13)) bus ();

    instruction_sequencer #(.PC_WIDTH(13), .STACK_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {alu_op, sel_l, status_wr, f_wr, w_wr, rd, flush, incr, j, ret}
    logic [12:0] ctl_vec;
    assign ctl_vec = {bus.alu_op, bus.alu_sel_l, bus.alu_status_wr_en, bus.f_wr_en,
                      bus.w_wr_en, bus.instr_rd_en, bus.instr_flush, bus.pc_incr_en,
                      bus.pc_j_en, bus.pc_ret_en};

    logic [2:0] flags;
    assign flags = {bus.stack_overflow, bus.stack_underflow, bus.illegal_instr};

    logic [12:0] ctl_s [4];
    logic [12:0] ret_s [4];
    logic [1:0]  qp_s  [4];

    function automatic logic [12:0] exp_ctl(input logic [3:0] op, input logic sel, input logic st,
                                            input logic fw, input logic ww, input logic rd,
                                            input logic fl, input logic inc, input logic j,
                                            input logic rt);
        return {op, sel, st, fw, ww, rd, fl, inc, j, rt};
    endfunction

    localparam logic [12:0] CtlSeq3  = 13'b0000_0000_10100;
    localparam logic [12:0] CtlSkip3 = 13'b0000_0000_01100;
    localparam logic [12:0] CtlJmp3  = 13'b0000_0000_01010;
    localparam logic [12:0] CtlRet3  = 13'b0000_0000_01001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one 4-cycle slot, sampling outputs 1 time unit after inputs settle.
    task automatic run_slot(input logic [13:0] ins, input logic [12:0] pcn,
                            input logic z, input logic bt);
        bus.instr_current = ins;
        bus.pc_next_addr  = pcn;
        bus.status_z      = z;
        bus.bit_test_res  = bt;
        for (int q = 0; q < 4; q++) begin
            #1;
            ctl_s[q] = ctl_vec;
            ret_s[q] = bus.ret_addr;
            qp_s[q]  = bus.q_phase;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic slot_check(input string tag, input logic [13:0] ins, input logic z,
                              input logic bt, input logic [12:0] e2, input logic [12:0] e3);
        run_slot(ins, 13'h0000, z, bt);
        check({tag, "_q1"}, ctl_s[1], 0);
        check({tag, "_q2"}, ctl_s[2], e2);
        check({tag, "_q3"}, ctl_s[3], e3);
    endtask

    initial begin
        bus.instr_current = 14'h0000;
        bus.pc_next_addr  = 13'h0000;
        bus.status_z      = 1'b0;
        bus.bit_test_res  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_q", bus.q_phase, 0);
        check("rst_ret", bus.ret_addr, 0);
        check("rst_flags", flags, 0);
        check("rst_cnt", dut.cnt_q, 0);

        // NOP run: 8 cycles
        for (int s = 0; s < 2; s++) begin
            run_slot(14'h0000, 13'h0000, 1'b0, 1'b0);
            for (int q = 0; q < 4; q++) begin
                check("nop_q", qp_s[q], q);
                check("nop_ctl", ctl_s[q], (q == 3) ? CtlSeq3 : 13'h0);
            end
        end

        // CALL then RETURN
        run_slot(14'h2005, 13'h0011, 1'b0, 1'b0);
        check("call_q2", ctl_s[2], 0);
        check("call_q3", ctl_s[3], CtlJmp3);
        #1 check("call_ret", bus.ret_addr, 13'h0011);
        run_slot(14'h0008, 13'h0000, 1'b0, 1'b0);
        check("return_q3", ctl_s[3], CtlRet3);
        check("return_addr", ret_s[3], 13'h0011);
        #1 check("return_cnt", dut.cnt_q, 0);
        check("return_flags", flags, 0);

        // RETLW after a CALL so the pop is legal
        run_slot(14'h2005, 13'h0022, 1'b0, 1'b0);
        run_slot(14'h3455, 13'h0000, 1'b0, 1'b0);
        check("retlw_q2", ctl_s[2], exp_ctl(AluPassLf, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        check("retlw_q3", ctl_s[3], CtlRet3);
        check("retlw_addr", ret_s[3], 13'h0022);
        #1 check("retlw_cnt", dut.cnt_q, 0);
        check("retlw_flags", flags, 0);

        // Overflow / underflow
        for (int k = 1; k <= 9; k++) begin
            run_slot(14'h2005, 13'(k), 1'b0, 1'b0);
            #1;
            if (k == 8) check("ovf_before", flags, 3'b000);
        end
        check("ovf_flag", flags, 3'b100);
        check("ovf_ret", bus.ret_addr, 9);
        check("ovf_cnt", dut.cnt_q, 8);
        for (int k = 0; k < 8; k++) begin
            run_slot(14'h0008, 13'h0000, 1'b0, 1'b0);
            check("pop_seq", ret_s[3], 9 - k);
        end
        #1 check("pop_flags", flags, 3'b100);
        run_slot(14'h0008, 13'h0000, 1'b0, 1'b0);
        check("unf_addr", ret_s[3], 9);
        #1 check("unf_flags", flags, 3'b110);
        check("unf_cnt", dut.cnt_q, 0);

        // DECFSZ skip / no skip
        slot_check("decfsz_z1", 14'h0BA0, 1'b1, 1'b0,
                   exp_ctl(AluDec, 0, 1, 1, 0, 0, 0, 0, 0, 0), CtlSkip3);
        slot_check("decfsz_z0", 14'h0BA0, 1'b0, 1'b0,
                   exp_ctl(AluDec, 0, 1, 1, 0, 0, 0, 0, 0, 0), CtlSeq3);

        // Assorted decodes
        slot_check("addwf", 14'h0720, 1'b0, 1'b0,
                   exp_ctl(AluAdd, 0, 1, 0, 1, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("swapf", 14'h0EA0, 1'b0, 1'b0,
                   exp_ctl(AluSwap, 0, 0, 1, 0, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("movwf", 14'h00A0, 1'b0, 1'b0,
                   exp_ctl(AluPassW, 0, 0, 1, 0, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("clrw", 14'h0100, 1'b0, 1'b0,
                   exp_ctl(AluClr, 0, 1, 0, 1, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("bsf", 14'h15A0, 1'b0, 1'b0,
                   exp_ctl(AluBs, 0, 0, 1, 0, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("btfss", 14'h1DA0, 1'b0, 1'b1,
                   exp_ctl(AluBs, 0, 0, 0, 0, 0, 0, 0, 0, 0), CtlSkip3);
        slot_check("btfsc", 14'h19A0, 1'b1, 1'b0,
                   exp_ctl(AluBc, 0, 0, 0, 0, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("sublw", 14'h3C05, 1'b0, 1'b0,
                   exp_ctl(AluSub, 1, 1, 0, 1, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("movlw", 14'h3000, 1'b0, 1'b0,
                   exp_ctl(AluPassLf, 1, 0, 0, 1, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("xorlw", 14'h3A0F, 1'b0, 1'b0,
                   exp_ctl(AluXor, 1, 1, 0, 1, 0, 0, 0, 0, 0), CtlSeq3);
        slot_check("goto", 14'h2805, 1'b0, 1'b0, 13'h0, CtlJmp3);

        // Illegal opcode, then reset in Q2 of a CALL
        slot_check("illegal", 14'h0064, 1'b0, 1'b0, 13'h0, CtlSeq3);
        #1 check("illegal_flag", bus.illegal_instr, 1);
        bus.instr_current = 14'h2005;
        bus.pc_next_addr  = 13'h0055;
        @(posedge clk);
        @(posedge clk);
        #2 check("pre_rst_q", bus.q_phase, 2);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_q", bus.q_phase, 0);
        check("mid_rst_flags", flags, 0);
        check("mid_rst_cnt", dut.cnt_q, 0);
        check("mid_rst_ret", bus.ret_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
